// File: rtl/tube_scheduler_pkg.sv
// tube_scheduler_pkg: shared FSM states and display constants for the tube scheduler
package tube_scheduler_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CAPT, S_CONV, S_LOAD, S_DWELL} state_t;
  localparam logic [3:0] SIGN_POS = 4'd0;
  localparam logic [3:0] SIGN_NEG = 4'd1;
  localparam logic [9:0] MAG_MAX = 10'd999;
  localparam logic [3:0] CONV_ITER = 4'd10;
endpackage

// File: rtl/tube_scheduler_bin2bcd_seq.sv
// tube_scheduler_bin2bcd_seq: sequential double-dabble, one shift-add-3 step per cycle
module tube_scheduler_bin2bcd_seq
  import tube_scheduler_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [9:0]  bin,
  output logic        done,
  output logic [11:0] bcd
);
  logic [21:0] sh, adj, nxt;
  logic [3:0] cnt;
  logic run;
  // add 3 to every BCD digit >= 5 before the shift
  always_comb begin
    adj = sh;
    for (int d = 0; d < 3; d++)
      if (sh[10+4*d +: 4] >= 4'd5) adj[10+4*d +: 4] = sh[10+4*d +: 4] + 4'd3;
  end
  assign nxt = adj << 1;
  assign bcd = nxt[21:10];
  assign done = run && cnt == CONV_ITER - 4'd1;
  // load on start, then iterate until the last step has been taken
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sh <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      sh <= {12'd0, bin};
      cnt <= '0;
      run <= 1'b1;
    end else if (run) begin
      sh <= nxt;
      cnt <= cnt + 4'd1;
      if (done) run <= 1'b0;
    end
  end
endmodule

// File: rtl/tube_scheduler.sv
// tube_scheduler: round-robin owner of the 7-segment tube with dwell time and BCD conversion
module tube_scheduler
  import tube_scheduler_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int DWELL_CYC = 20_000_000
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [13*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     grant,
  output logic [15:0]          disp_data,
  output logic                 disp_load,
  output logic                 ovf,
  output logic                 busy
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(DWELL_CYC);
  localparam logic [CW-1:0] DMAX = CW'(DWELL_CYC - 1);
  localparam logic [IW-1:0] PTR_RST = IW'(N_REQ - 1);
  state_t state, state_nxt;
  logic [IW-1:0] own, ptr, base, sel;
  logic own_v, fresh, found, own_req, expire, start, done, sign_q, ovf_q;
  logic [CW-1:0] dcnt;
  logic [12:0] slot;
  logic [9:0] mag_c;
  logic [11:0] bcd;
  assign own_req = req_valid[own];
  assign expire = state == S_DWELL && dcnt == DMAX;
  assign base = (state == S_DWELL) ? own : ptr;
  assign start = state == S_CAPT && own_req;
  assign grant = own_v ? N_REQ'(1) << own : '0;
  assign req_ready = start ? grant : '0;
  assign busy = state != S_IDLE;
  assign mag_c = (slot[11:0] > {2'b00, MAG_MAX}) ? MAG_MAX : slot[9:0];
  // select the owner's request slot
  always_comb begin
    slot = '0;
    for (int i = 0; i < N_REQ; i++)
      if (own == IW'(i)) slot = req_data[13*i +: 13];
  end
  // round-robin search starting after base, base itself is checked last
  always_comb begin
    found = 1'b0;
    sel = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      int idx;
      idx = int'(base) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      for (int i = 0; i < N_REQ; i++)
        if (!found && idx == i && req_valid[i]) begin
          found = 1'b1;
          sel = IW'(i);
        end
    end
  end
  // next-state logic; expiry outranks a refresh request
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = found ? S_CAPT : S_IDLE;
      S_CAPT:  state_nxt = own_req ? S_CONV : S_IDLE;
      S_CONV:  state_nxt = done ? S_LOAD : S_CONV;
      S_LOAD:  state_nxt = S_DWELL;
      S_DWELL: state_nxt = expire ? (found ? S_CAPT : S_IDLE) : (own_req ? S_CAPT : S_DWELL);
      default: state_nxt = S_IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk) begin
    if (!rstn) state <= S_IDLE;
    else state <= state_nxt;
  end
  // ownership, dwell counter and display registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      own <= '0;
      own_v <= 1'b0;
      ptr <= PTR_RST;
      fresh <= 1'b0;
      dcnt <= '0;
      sign_q <= 1'b0;
      ovf_q <= 1'b0;
      disp_data <= '0;
      disp_load <= 1'b0;
      ovf <= 1'b0;
    end else begin
      disp_load <= state == S_CONV && done;
      dcnt <= (state == S_LOAD && fresh) ? '0 : (dcnt == DMAX ? dcnt : dcnt + CW'(1));
      if (state == S_LOAD) fresh <= 1'b0;
      if (start) begin
        sign_q <= slot[12] && slot[11:0] != 12'd0;
        ovf_q <= slot[11:0] > {2'b00, MAG_MAX};
      end
      if (state == S_CONV && done) begin
        disp_data <= {sign_q ? SIGN_NEG : SIGN_POS, bcd};
        ovf <= ovf_q;
      end
      if ((state == S_IDLE || expire) && found) begin
        own <= sel;
        own_v <= 1'b1;
        fresh <= 1'b1;
      end else if ((state == S_CAPT && !own_req) || expire) begin
        own_v <= 1'b0;
      end
      if (expire) ptr <= own;
    end
  end
  tube_scheduler_bin2bcd_seq u_b2b (
    .clk(clk),
    .rstn(rstn),
    .start(start),
    .bin(mag_c),
    .done(done),
    .bcd(bcd)
  );
endmodule

// File: tb/tb_tube_scheduler.sv
// tb_tube_scheduler: directed checks of arbitration, dwell, refresh, conversion and reset
module tb_tube_scheduler;
  logic clk = 1'b0;
  logic rstn;
  logic [2:0] req_valid;
  logic [38:0] req_data;
  logic [2:0] req_ready, grant;
  logic [15:0] disp_data;
  logic disp_load, ovf, busy;
  int n_cmp = 0;
  int n_err = 0;
  int cyc_n = 0;
  int l_cyc, n;
  logic [2:0] seq [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  logic [15:0] val [4] = '{16'h0111, 16'h0222, 16'h0333, 16'h0111};
  tube_scheduler #(.N_REQ(3), .DWELL_CYC(100)) dut (
    .clk(clk),
    .rstn(rstn),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .grant(grant),
    .disp_data(disp_data),
    .disp_load(disp_load),
    .ovf(ovf),
    .busy(busy)
  );
  always #5 clk = ~clk;
  // free-running cycle index for latency measurements
  always @(posedge clk) cyc_n <= cyc_n + 1;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] probe(input int s);
    return s == 0 ? 32'(req_ready) : s == 1 ? 32'(disp_load) : s == 2 ? 32'(grant) : 32'(busy);
  endfunction
  task automatic wait_until(input string tag, input int s, input logic [31:0] v, input int lim);
    int c;
    c = 0;
    while (probe(s) !== v && c < lim) begin
      tick();
      c++;
    end
    chk(tag, probe(s), v);
  endtask
  task automatic set_slot(input int i, input logic s, input logic [11:0] m);
    req_data[13*i +: 13] = {s, m};
  endtask
  task automatic do_reset();
    rstn = 1'b0;
    req_valid = '0;
    tick();
    tick();
    rstn = 1'b1;
  endtask
  initial begin
    req_data = '0;
    do_reset();
    chk("rst_grant", grant, 0);
    chk("rst_data", disp_data, 16'h0000);
    chk("rst_load", disp_load, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    set_slot(0, 1'b0, 12'd123);
    req_valid = 3'b001;
    tick();
    chk("t2_ready", req_ready, 3'b001);
    chk("t2_grant", grant, 3'b001);
    chk("t2_busy", busy, 1);
    tick();
    chk("t2_ready_pulse", req_ready, 3'b000);
    req_valid = 3'b000;
    repeat (9) tick();
    chk("t2_load_early", disp_load, 0);
    tick();
    chk("t2_load", disp_load, 1);
    chk("t2_data", disp_data, 16'h0123);
    chk("t2_ovf", ovf, 0);
    tick();
    chk("t2_load_strobe", disp_load, 0);
    chk("t2_data_hold", disp_data, 16'h0123);
    set_slot(1, 1'b1, 12'd4095);
    req_valid = 3'b010;
    wait_until("t3_ready", 0, 3'b010, 200);
    chk("t3_grant", grant, 3'b010);
    tick();
    req_valid = 3'b000;
    wait_until("t3_load", 1, 1, 20);
    chk("t3_data_sat", disp_data, 16'h1999);
    chk("t3_ovf_sat", ovf, 1);
    set_slot(1, 1'b1, 12'd0);
    req_valid = 3'b010;
    wait_until("t3_ready0", 0, 3'b010, 20);
    tick();
    req_valid = 3'b000;
    wait_until("t3_load0", 1, 1, 20);
    chk("t3_data_zero", disp_data, 16'h0000);
    chk("t3_ovf_zero", ovf, 0);
    chk("t3_grant_keep", grant, 3'b010);
    wait_until("t3_idle", 3, 0, 200);
    chk("t3_grant_idle", grant, 0);
    do_reset();
    set_slot(0, 1'b0, 12'd111);
    set_slot(1, 1'b0, 12'd222);
    set_slot(2, 1'b0, 12'd333);
    req_valid = 3'b111;
    for (int k = 0; k < 4; k++) begin
      wait_until("t4_grant", 2, 32'(seq[k]), 400);
      wait_until("t4_load", 1, 1, 20);
      chk("t4_data", disp_data, 32'(val[k]));
      if (k < 3) begin
        n = 0;
        while (grant === seq[k] && n < 300) begin
          tick();
          n++;
        end
        chk("t4_hold", 32'(n >= 100), 1);
      end
    end
    do_reset();
    set_slot(0, 1'b0, 12'd123);
    set_slot(1, 1'b0, 12'd789);
    req_valid = 3'b001;
    wait_until("t5_ready", 0, 3'b001, 10);
    tick();
    req_valid = 3'b000;
    wait_until("t5_load", 1, 1, 20);
    l_cyc = cyc_n;
    req_valid = 3'b010;
    repeat (40) tick();
    set_slot(0, 1'b0, 12'd456);
    req_valid = 3'b011;
    wait_until("t5_rready", 0, 3'b001, 20);
    tick();
    req_valid = 3'b010;
    wait_until("t5_rload", 1, 1, 20);
    chk("t5_rdata", disp_data, 16'h0456);
    chk("t5_rgrant", grant, 3'b001);
    wait_until("t5_grant1", 2, 3'b010, 100);
    chk("t5_expiry_cycle", cyc_n - l_cyc, 101);
    tick();
    chk("t6_busy_conv", busy, 1);
    rstn = 1'b0;
    tick();
    chk("t6_grant", grant, 0);
    chk("t6_busy", busy, 0);
    chk("t6_data", disp_data, 16'h0000);
    chk("t6_load", disp_load, 0);
    chk("t6_ovf", ovf, 0);
    chk("t6_ready", req_ready, 0);
    rstn = 1'b1;
    req_valid = 3'b111;
    tick();
    chk("t6_first_grant", grant, 3'b001);
    chk("t6_first_ready", req_ready, 3'b001);
    wait_until("t6_load_after", 1, 1, 20);
    chk("t6_data_after", disp_data, 16'h0456);
    req_valid = 3'b000;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
